// File: rtl/damage_sequencer.sv
// ============================================================================
// Module   : damage_sequencer
// Brief    : Multi-cycle attack pipeline: power*multiplier, crit doubling,
//            clamp to 15, then saturating HP subtraction on the target.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module damage_sequencer #(
    parameter int MAX_HP = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       attacker,
    input  logic [3:0] move_power,
    input  logic [1:0] multiplier,
    input  logic       crit,
    input  logic       new_game,
    output logic       busy,
    output logic       done,
    output logic [3:0] damage,
    output logic [3:0] p_hp,
    output logic [3:0] a_hp,
    output logic       hp_is_zero
);

    localparam logic [3:0] c_max_hp = 4'(MAX_HP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_CRIT  = 3'd2,
        S_CLAMP = 3'd3,
        S_APPLY = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t     r_state;
    logic       r_attacker;
    logic [3:0] r_power;
    logic [1:0] r_mult;
    logic       r_crit;
    logic [6:0] r_product;
    logic [5:0] w_mul_product;

    assign w_mul_product = {2'b00, r_power} * {4'b0000, r_mult};
    assign hp_is_zero    = (p_hp == 4'd0) || (a_hp == 4'd0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_attacker <= 1'b0;
            r_power    <= 4'd0;
            r_mult     <= 2'd0;
            r_crit     <= 1'b0;
            r_product  <= 7'd0;
            p_hp       <= c_max_hp;
            a_hp       <= c_max_hp;
            damage     <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // new_game has priority and suppresses a coincident start
                    if (new_game) begin
                        p_hp   <= c_max_hp;
                        a_hp   <= c_max_hp;
                        damage <= 4'd0;
                    end else if (start && !hp_is_zero) begin
                        r_attacker <= attacker;
                        r_power    <= move_power;
                        r_mult     <= multiplier;
                        r_crit     <= crit;
                        busy       <= 1'b1;
                        r_state    <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_product <= {1'b0, w_mul_product};
                    r_state   <= S_CRIT;
                end
                S_CRIT: begin
                    if (r_crit) begin
                        r_product <= r_product + r_product;
                    end
                    r_state <= S_CLAMP;
                end
                S_CLAMP: begin
                    damage  <= (r_product > 7'd15) ? 4'd15 : r_product[3:0];
                    r_state <= S_APPLY;
                end
                S_APPLY: begin
                    if (!r_attacker) begin
                        a_hp <= (a_hp > damage) ? (a_hp - damage) : 4'd0;
                    end else begin
                        p_hp <= (p_hp > damage) ? (p_hp - damage) : 4'd0;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // done is registered, so it is seen in the first IDLE cycle
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/damage_sequencer.md
DAMAGE_SEQUENCER -- requirements
Module: damage_sequencer

Interface
REQ-001 SHALL have parameter MAX_HP, default 15, meaning the HP both Pokemon hold after reset or new_game (range 1..15).
REQ-002 SHALL have these ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  reset, synchronous, active-low.
- start  input  1  request one attack, sampled in IDLE only.
- attacker  input  1  0 = player attacks AI; 1 = AI attacks player.
- move_power  input  4  base power, 0..15.
- multiplier  input  2  type multiplier, 0..3.
- crit  input  1  critical hit; doubles the product.
- new_game  input  1  restore both HP to MAX_HP, sampled in IDLE only.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the attack is applied.
- damage  output  4  last applied damage.
- p_hp  output  4  player HP.
- a_hp  output  4  AI HP.
- hp_is_zero  output  1  high while p_hp==0 or a_hp==0.

Function
REQ-003 SHALL implement the states IDLE, MUL, CRIT, CLAMP, APPLY and DONE, with one state per clock cycle.
REQ-004 SHALL sample start in IDLE, and only while hp_is_zero==0 and new_game==0.
REQ-005 On an accepted start, SHALL latch attacker, move_power, multiplier and crit, then go to MUL.
REQ-006 In MUL, SHALL form a 6-bit product = move_power*multiplier, then go to CRIT.
REQ-007 In CRIT, SHALL form product = product+product (7-bit) if the latched crit is 1, else hold product, then go to CLAMP.
REQ-008 In CLAMP, SHALL set damage = min(product,15), then go to APPLY.
REQ-009 In APPLY, SHALL set target HP = target HP - damage, saturating at 0, then go to DONE.
- Target is a_hp when the latched attacker==0, else p_hp.
- The non-target HP SHALL be unchanged.
REQ-010 In DONE, SHALL assert done for exactly one cycle, then go to IDLE.
REQ-011 Latency: done SHALL be high in the cycle following the 5th rising edge after the edge that accepted start.
- The HP and damage updates SHALL be visible in that same cycle.
REQ-012 Back-to-back: start may be accepted in the cycle after DONE, giving a minimum spacing of 6 cycles per attack.
REQ-013 start SHALL be ignored in every non-IDLE state; the latched operands SHALL not change while busy.
REQ-014 start SHALL be ignored while hp_is_zero==1: no state change, no done.
REQ-015 new_game in IDLE SHALL set p_hp=a_hp=MAX_HP and damage=0 on the next edge; new_game SHALL be ignored while busy.
REQ-016 If start and new_game are both high in IDLE, new_game SHALL win and start SHALL be dropped.
REQ-017 multiplier==0 or move_power==0 SHALL give damage=0 with HP unchanged; done SHALL still pulse.
REQ-018 hp_is_zero SHALL be combinational from the p_hp and a_hp registers.

Reset
REQ-019 While reset_n==0 at a rising edge, SHALL set:
- state = IDLE;
- p_hp = a_hp = MAX_HP;
- damage = 0;
- done = 0, busy = 0;
- latched operands = 0.
REQ-020 Reset asserted in any state, including APPLY, SHALL abort the attack, with no partial HP update and no done.

Verification
REQ-021 Reset -> p_hp=15, a_hp=15, damage=0, busy=0, done=0, hp_is_zero=0.
REQ-022 attacker=0, power=3, mult=2, crit=0 -> damage=6, a_hp=9, p_hp=15, done one cycle 5 edges after start.
REQ-023 attacker=1, power=5, mult=3, crit=1 (product 30) -> damage=15, p_hp=0, hp_is_zero=1; a following start produces no done and busy stays 0.
REQ-024 start re-pulsed during MUL..DONE with different operands -> exactly one done, result from the first operands only.
REQ-025 new_game in IDLE after REQ-023 -> p_hp=a_hp=15, hp_is_zero=0; new_game pulsed while busy -> ignored.
REQ-026 attacker=0, power=9, mult=0 -> damage=0, HP unchanged, done pulses; reset_n low during APPLY -> HP=15, done never asserts.
